// File: rtl/cursor_selector.sv
// ----------------------------------------------------------------------------
// cursor_selector
//
// Tracks a cursor over an N x N game board. The cursor can be moved one cell
// in four directions, with wrap at the edges. It can also seek the next free
// cell in raster order; the seek takes several cycles. The block renders the
// board grid plus a cursor mark into a registered 16x16 green LED frame.
//
// Optional feature, macro CURSOR_BLINK_EN:
//   When defined, the cursor mark blinks with a half-period of BLINK_DIV
//   cycles. Any accepted move, or the end of a seek, makes the mark visible
//   again immediately. When undefined, the mark is drawn continuously.
//
// Ports:
//   clock       system clock
//   reset       asynchronous, active-high reset
//   up/down     single-cycle move request, row -1 / row +1 (wraps modulo N)
//   left/right  single-cycle move request, col -1 / col +1 (wraps modulo N)
//   next        single-cycle request to seek the next free cell
//   occupied    bit i set means cell i (i = row*N+col) is taken
//   cursor_idx  current cell index, row*N+col
//   busy        high while a seek is in progress
//   full        registered AND of occupied
//   GrnPixels   registered frame, GrnPixels[r][c] = row r, column c
// ----------------------------------------------------------------------------
module cursor_selector #(
    parameter int N         = 3,
    parameter int PITCH     = 5,
    parameter int OFFSET    = 2,
    parameter int MARK      = 2,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   up,
    input  logic                   down,
    input  logic                   left,
    input  logic                   right,
    input  logic                   next,
    input  logic [N*N-1:0]         occupied,
    output logic [$clog2(N*N)-1:0] cursor_idx,
    output logic                   busy,
    output logic                   full,
    output logic [15:0][15:0]      GrnPixels
);

    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam int RW = $clog2(N);
    localparam int NP = N * PITCH;

    // Reject geometries that cannot fit the 16x16 frame.
    generate
        if (N < 2 || NP > 16 || OFFSET + MARK > PITCH || BLINK_DIV < 1) begin : g_param_check
            $error("cursor_selector: illegal parameter combination");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        SEEK
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [RW-1:0]   col_q, col_d;
    logic [RW-1:0]   probe_row_q, probe_row_d;
    logic [RW-1:0]   probe_col_q, probe_col_d;
    logic [IW-1:0]   start_q, start_d;
    logic            full_q;

    logic [RW-1:0]   cand_row, cand_col;
    logic [IW-1:0]   cand_idx;

    logic [15:0][15:0] frame_d;
    logic            mark_en;
    int              mark_r0, mark_c0;

    function automatic logic [IW-1:0] cell_index(input logic [RW-1:0] r,
                                                 input logic [RW-1:0] c);
        return IW'(r) * IW'(N) + IW'(c);
    endfunction

    assign cursor_idx = cell_index(row_q, col_q);
    assign busy       = (state_q == SEEK);
    assign full       = full_q;

    // Seek probe walks row/col in raster order, so no division is needed to
    // split the candidate index back into a position.
    always_comb begin
        cand_row = probe_row_q;
        cand_col = probe_col_q + RW'(1);
        if (probe_col_q == RW'(N - 1)) begin
            cand_col = '0;
            cand_row = (probe_row_q == RW'(N - 1)) ? '0 : probe_row_q + RW'(1);
        end
    end

    assign cand_idx = cell_index(cand_row, cand_col);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case/if tree can leave a latch behind.
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        probe_row_d = probe_row_q;
        probe_col_d = probe_col_q;
        start_d     = start_q;

        case (state_q)
            IDLE: begin
                // A request on next is consumed even when the board is full,
                // so it never falls through to a simultaneous move.
                if (next) begin
                    if (!full_q) begin
                        state_d     = SEEK;
                        start_d     = cursor_idx;
                        probe_row_d = row_q;
                        probe_col_d = col_q;
                    end
                end else if (up) begin
                    row_d = (row_q == '0) ? RW'(N - 1) : row_q - RW'(1);
                end else if (down) begin
                    row_d = (row_q == RW'(N - 1)) ? '0 : row_q + RW'(1);
                end else if (left) begin
                    col_d = (col_q == '0) ? RW'(N - 1) : col_q - RW'(1);
                end else if (right) begin
                    col_d = (col_q == RW'(N - 1)) ? '0 : col_q + RW'(1);
                end
            end

            SEEK: begin
                // Back at the start cell: every other cell was taken, so the
                // cursor stays where it was.
                if (cand_idx == start_q) begin
                    state_d = IDLE;
                end else if (!occupied[cand_idx]) begin
                    state_d = IDLE;
                    row_d   = cand_row;
                    col_d   = cand_col;
                end else begin
                    probe_row_d = cand_row;
                    probe_col_d = cand_col;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            probe_row_q <= '0;
            probe_col_q <= '0;
            start_q     <= '0;
            full_q      <= 1'b0;
            // NOTE: the frame is a plain register bank, not a RAM, so it is
            // reset with everything else and the LEDs stay dark in reset.
            GrnPixels   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the same
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            probe_row_q <= probe_row_d;
            probe_col_q <= probe_col_d;
            start_q     <= start_d;
            full_q      <= &occupied;
            GrnPixels   <= frame_d;
        end
    end

    // ------------------------------------------------------------------------
    // Frame rendering, from the current cursor position (the frame register
    // therefore trails the state by one cycle).
    // ------------------------------------------------------------------------
    function automatic logic on_grid_line(input int p);
        return (p > 0) && (p < NP) && ((p % PITCH) == 0);
    endfunction

    function automatic logic in_grid_span(input int p);
        return (p >= 1) && (p < NP);
    endfunction

    assign mark_r0 = int'(row_q) * PITCH + OFFSET;
    assign mark_c0 = int'(col_q) * PITCH + OFFSET;

    always_comb begin
        frame_d = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                frame_d[r][c] = (on_grid_line(r) && in_grid_span(c))
                             || (on_grid_line(c) && in_grid_span(r))
                             || (mark_en
                                 && (r >= mark_r0) && (r < mark_r0 + MARK)
                                 && (c >= mark_c0) && (c < mark_c0 + MARK));
            end
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] blink_cnt_q;
    logic          phase_q;
    logic          cursor_event;

    // With N >= 2 every accepted move changes the position, so a position
    // change plus the SEEK->IDLE transition covers all restart events.
    assign cursor_event = (row_d != row_q) || (col_d != col_q)
                       || (state_q == SEEK && state_d == IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (cursor_event) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + CW'(1);
        end
    end

    assign mark_en = phase_q;
`else
    assign mark_en = 1'b1;
`endif

endmodule

// File: tb/tb_cursor_selector.sv
// ----------------------------------------------------------------------------
// tb_cursor_selector
//
// Self-checking bench for cursor_selector with N=3, PITCH=5, OFFSET=2,
// MARK=2 (default build, continuous cursor mark). A behavioural model tracks
// the cursor as a plain cell number and renders the expected frame from the
// board geometry. The model is compared on every clock step. Hand-derived
// constants cover the documented scenarios and a vector table.
// ----------------------------------------------------------------------------
module tb_cursor_selector;

    localparam int N      = 3;
    localparam int PITCH  = 5;
    localparam int OFFSET = 2;
    localparam int MARK   = 2;
    localparam int NN     = N * N;
    localparam int NP     = N * PITCH;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic              next = 1'b0;
    logic [NN-1:0]     occupied = '0;
    logic [3:0]        cursor_idx;
    logic              busy;
    logic              full;
    logic [15:0][15:0] GrnPixels;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    int                m_cur;
    int                m_probe;
    int                m_start;
    bit                m_seek;
    bit                m_full;
    logic [15:0][15:0] m_frame;

    typedef struct packed {
        logic          u, d, l, r, nx;
        logic [NN-1:0] occ;
        logic [3:0]    idx;
        logic          bsy;
        logic          fl;
    } vec_t;

    vec_t vecs [12];

    always #5 clock = ~clock;

    cursor_selector #(
        .N(N), .PITCH(PITCH), .OFFSET(OFFSET), .MARK(MARK)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .next       (next),
        .occupied   (occupied),
        .cursor_idx (cursor_idx),
        .busy       (busy),
        .full       (full),
        .GrnPixels  (GrnPixels)
    );

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected LED frame for a cursor on cell cur, built from the geometry.
    function automatic logic [15:0][15:0] render(input int cur);
        logic [15:0][15:0] f;
        int r0, c0;
        f  = '0;
        r0 = (cur / N) * PITCH + OFFSET;
        c0 = (cur % N) * PITCH + OFFSET;
        for (int k = 1; k < N; k++) begin
            for (int i = 1; i < NP; i++) begin
                f[k*PITCH][i] = 1'b1;
                f[i][k*PITCH] = 1'b1;
            end
        end
        for (int i = 0; i < MARK; i++)
            for (int j = 0; j < MARK; j++)
                f[r0+i][c0+j] = 1'b1;
        return f;
    endfunction

    task automatic model_reset();
        m_cur   = 0;
        m_probe = 0;
        m_start = 0;
        m_seek  = 0;
        m_full  = 0;
        m_frame = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [15:0][15:0] nf;
        bit nfull;
        int r, c, p;
        nf    = render(m_cur);
        nfull = &occupied;
        r     = m_cur / N;
        c     = m_cur % N;
        if (m_seek) begin
            p = (m_probe + 1) % NN;
            if (p == m_start) begin
                m_seek = 0;
            end else if (!occupied[p]) begin
                m_cur  = p;
                m_seek = 0;
            end else begin
                m_probe = p;
            end
        end else if (next) begin
            if (!m_full) begin
                m_seek  = 1;
                m_start = m_cur;
                m_probe = m_cur;
            end
        end else if (up)    m_cur = ((r + N - 1) % N) * N + c;
        else if (down)      m_cur = ((r + 1) % N) * N + c;
        else if (left)      m_cur = r * N + (c + N - 1) % N;
        else if (right)     m_cur = r * N + (c + 1) % N;
        m_full  = nfull;
        m_frame = nf;
    endtask

    task automatic compare_model();
        check("model_idx",   cursor_idx, m_cur);
        check("model_busy",  busy,       m_seek);
        check("model_full",  full,       m_full);
        check("model_frame", GrnPixels,  m_frame);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic clear_inputs();
        up = 0; down = 0; left = 0; right = 0; next = 0;
    endtask

    // Asserts reset away from any clock edge, checks the async reset values,
    // then releases it just after a rising edge.
    task automatic do_reset();
        clear_inputs();
        #1 reset = 1'b1;
        #1;
        check("reset_idx",   cursor_idx, 0);
        check("reset_busy",  busy,       0);
        check("reset_full",  full,       0);
        check("reset_frame", GrnPixels,  0);
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        // ---------------- Reset and initial frame ----------------
        do_reset();
        occupied = '0;
        step();
        step();
        check("init_idx",    cursor_idx,   0);
        check("init_busy",   busy,         0);
        check("init_full",   full,         0);
        check("init_row0",   GrnPixels[0], 16'h0000);
        check("init_row2",   GrnPixels[2], 16'h042C);
        check("init_row3",   GrnPixels[3], 16'h042C);
        check("init_row5",   GrnPixels[5], 16'h7FFE);
        check("init_row14",  GrnPixels[14], 16'h0420);
        check("init_row15",  GrnPixels[15], 16'h0000);

        // ---------------- Wrap left then up ----------------
        left = 1; step(); clear_inputs();
        check("wrap_left_idx", cursor_idx, 2);
        up = 1; step(); clear_inputs();
        check("wrap_up_idx", cursor_idx, 8);
        step();
        check("mark8_row12", GrnPixels[12], 16'h3420);
        check("mark8_row13", GrnPixels[13], 16'h3420);
        check("mark8_row2",  GrnPixels[2],  16'h0420);

        // ---------------- Vector table, starting from cell 8 ----------------
        //            u  d  l  r  nx occ       idx  bsy fl
        vecs[0]  = '{0, 0, 0, 0, 0, 9'h000, 4'd8, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 9'h000, 4'd2, 0, 0};
        vecs[2]  = '{0, 0, 0, 1, 0, 9'h000, 4'd0, 0, 0};
        vecs[3]  = '{0, 0, 1, 0, 0, 9'h000, 4'd2, 0, 0};
        vecs[4]  = '{1, 0, 0, 0, 0, 9'h000, 4'd8, 0, 0};
        vecs[5]  = '{0, 0, 1, 0, 0, 9'h1FF, 4'd7, 0, 1};
        vecs[6]  = '{0, 0, 1, 1, 0, 9'h1FF, 4'd6, 0, 1};
        vecs[7]  = '{1, 1, 0, 0, 0, 9'h000, 4'd3, 0, 0};
        vecs[8]  = '{0, 1, 1, 0, 0, 9'h000, 4'd6, 0, 0};
        vecs[9]  = '{0, 0, 0, 1, 0, 9'h000, 4'd7, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 9'h1FF, 4'd7, 0, 1};
        vecs[11] = '{0, 0, 0, 0, 1, 9'h1FF, 4'd7, 0, 1};
        for (int i = 0; i < 12; i++) begin
            up = vecs[i].u; down = vecs[i].d; left = vecs[i].l;
            right = vecs[i].r; next = vecs[i].nx; occupied = vecs[i].occ;
            step();
            clear_inputs();
            check($sformatf("vec%0d_idx", i),  cursor_idx, vecs[i].idx);
            check($sformatf("vec%0d_busy", i), busy,       vecs[i].bsy);
            check($sformatf("vec%0d_full", i), full,       vecs[i].fl);
        end

        // ---------------- Seek skipping cells 1 and 2 ----------------
        do_reset();
        occupied = 9'b000000111;
        next = 1; step(); clear_inputs();
        check("seek3_busy_c1", busy, 1);
        step();
        check("seek3_busy_c2", busy, 1);
        step();
        check("seek3_busy_c3", busy, 1);
        check("seek3_idx_mid", cursor_idx, 0);
        step();
        check("seek3_busy_end", busy, 0);
        check("seek3_idx_end",  cursor_idx, 3);

        // ---------------- Seek wrapping back to start ----------------
        do_reset();
        occupied = 9'b111111110;
        next = 1; step(); clear_inputs();
        check("wrap_busy_entry", busy, 1);
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("wrap_busy_probe%0d", k + 1), busy, 1);
        end
        step();
        check("wrap_busy_end", busy, 0);
        check("wrap_idx_end",  cursor_idx, 0);
        occupied = '1;
        step();
        check("full_set", full, 1);
        next = 1; step(); clear_inputs();
        check("full_next_busy", busy, 0);
        step();
        check("full_next_busy2", busy, 0);
        check("full_next_idx",   cursor_idx, 0);

        // ---------------- Inputs ignored during seek; next beats up ----------
        do_reset();
        occupied = 9'b000000111;
        next = 1; step(); clear_inputs();
        right = 1; next = 1; step(); clear_inputs();
        check("ign_busy", busy, 1);
        check("ign_idx",  cursor_idx, 0);
        step();
        step();
        check("ign_busy_end", busy, 0);
        check("ign_idx_end",  cursor_idx, 3);
        next = 1; up = 1; step(); clear_inputs();
        check("prio_busy", busy, 1);
        check("prio_idx",  cursor_idx, 3);
        step();
        check("prio_busy_end", busy, 0);
        check("prio_idx_end",  cursor_idx, 4);

        // ---------------- Reset in the middle of a seek ----------------
        do_reset();
        occupied = 9'b111111110;
        next = 1; step(); clear_inputs();
        step();
        step();
        check("midseek_busy_before", busy, 1);
        do_reset();
        step();
        check("midseek_after_idx",  cursor_idx, 0);
        check("midseek_after_busy", busy, 0);

        // ---------------- Randomised run against the model ----------------
        do_reset();
        occupied = '0;
        for (int t = 0; t < 600; t++) begin
            if (($urandom % 8) == 0) begin
                case ($urandom % 4)
                    0: occupied = '1;
                    1: occupied = NN'($urandom);
                    2: occupied = NN'($urandom | $urandom);
                    default: occupied = ~(NN'(1) << ($urandom % NN));
                endcase
            end
            up    = (($urandom % 6) == 0);
            down  = (($urandom % 6) == 0);
            left  = (($urandom % 6) == 0);
            right = (($urandom % 6) == 0);
            next  = (($urandom % 5) == 0);
            step();
            clear_inputs();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
